// File: rtl/seq_pkg.sv
// Shared state, opcode and control-word encodings for the multicycle sequencer.
package seq_pkg;

  localparam int CTRL_W = 16;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_HALT      = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    C_RTYPE, C_ITYPE, C_LW, C_SW, C_BNE, C_JUMP, C_HALT, C_ILLEGAL
  } op_class_e;

  localparam logic [5:0] OP_LW   = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b100001;
  localparam logic [5:0] OP_BNE  = 6'b110000;
  localparam logic [5:0] OP_J    = 6'b110001;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // Bit positions inside ctrl_word; two-bit fields give their LSB.
  localparam int B_PCWRITECOND = 15;
  localparam int B_PCWRITE     = 14;
  localparam int B_IORD        = 13;
  localparam int B_MEMREAD     = 12;
  localparam int B_MEMWRITE    = 11;
  localparam int B_MEMTOREG    = 10;
  localparam int B_IRWRITE     = 9;
  localparam int B_PCSOURCE    = 7;
  localparam int B_ALUOP       = 5;
  localparam int B_ALUSRCB     = 3;
  localparam int B_ALUSRCA     = 2;
  localparam int B_REGWRITE    = 1;
  localparam int B_REGDST      = 0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic op_class_e op_class(input logic [5:0] op);
    op_class_e c;
    casez (op)
      6'b00????: c = C_RTYPE;
      6'b01????: c = C_ITYPE;
      OP_LW:     c = C_LW;
      OP_SW:     c = C_SW;
      OP_BNE:    c = C_BNE;
      OP_J:      c = C_JUMP;
      OP_HALT:   c = C_HALT;
      default:   c = C_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seq_ctrl_decode.sv
// Combinational map from sequencer state to the packed datapath control word.
module seq_ctrl_decode
  import seq_pkg::*;
(
  input  state_e            state_i,
  input  logic              is_rtype_i,
  input  logic              mem_ready_i,
  output logic [CTRL_W-1:0] ctrl_word_o
);

  always_comb begin
    ctrl_word_o = '0;
    case (state_i)
      S_FETCH: begin
        // IR and PC update only on the cycle the instruction word arrives.
        ctrl_word_o[B_MEMREAD]      = 1'b1;
        ctrl_word_o[B_ALUSRCB +: 2] = SRCB_FOUR;
        ctrl_word_o[B_ALUOP +: 2]   = ALUOP_ADD;
        ctrl_word_o[B_IRWRITE]      = mem_ready_i;
        ctrl_word_o[B_PCWRITE]      = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_word_o[B_ALUSRCB +: 2] = SRCB_IMMSH;
        ctrl_word_o[B_ALUOP +: 2]   = ALUOP_ADD;
      end
      S_EXEC_R: begin
        ctrl_word_o[B_ALUSRCA]      = 1'b1;
        ctrl_word_o[B_ALUSRCB +: 2] = SRCB_REG;
        ctrl_word_o[B_ALUOP +: 2]   = ALUOP_RTYPE;
      end
      S_EXEC_I: begin
        ctrl_word_o[B_ALUSRCA]      = 1'b1;
        ctrl_word_o[B_ALUSRCB +: 2] = SRCB_IMM;
        ctrl_word_o[B_ALUOP +: 2]   = ALUOP_ITYPE;
      end
      S_ALU_WB: begin
        ctrl_word_o[B_REGWRITE] = 1'b1;
        ctrl_word_o[B_REGDST]   = is_rtype_i;
      end
      S_MEM_ADDR: begin
        ctrl_word_o[B_ALUSRCA]      = 1'b1;
        ctrl_word_o[B_ALUSRCB +: 2] = SRCB_IMM;
        ctrl_word_o[B_ALUOP +: 2]   = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl_word_o[B_IORD]    = 1'b1;
        ctrl_word_o[B_MEMREAD] = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_word_o[B_REGWRITE] = 1'b1;
        ctrl_word_o[B_MEMTOREG] = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_word_o[B_IORD]     = 1'b1;
        ctrl_word_o[B_MEMWRITE] = 1'b1;
      end
      S_BRANCH: begin
        ctrl_word_o[B_ALUSRCA]       = 1'b1;
        ctrl_word_o[B_ALUSRCB +: 2]  = SRCB_REG;
        ctrl_word_o[B_ALUOP +: 2]    = ALUOP_SUB;
        ctrl_word_o[B_PCWRITECOND]   = 1'b1;
        ctrl_word_o[B_PCSOURCE +: 2] = PCSRC_TARGET;
      end
      S_JUMP: begin
        ctrl_word_o[B_PCWRITE]       = 1'b1;
        ctrl_word_o[B_PCSOURCE +: 2] = PCSRC_JUMP;
      end
      default: ctrl_word_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM sequencing the fetch/decode/execute datapath.
// Define SEQ_PERF_CNT_EN to build the cycle_count / instr_retired counters.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int CTRL_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            opcode,
  input  logic                  alu_zero,
  input  logic                  mem_ready,
  output logic [CTRL_WIDTH-1:0] ctrl_word,
  output logic [3:0]            state_dbg,
  output logic                  halted,
  output logic                  illegal_op,
  output logic [31:0]           cycle_count,
  output logic [31:0]           instr_retired
);

  localparam bit          TMO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [31:0] TMO_LAST = 32'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        is_rtype_q, is_rtype_d;
  logic        illegal_q, illegal_d;
  logic [31:0] tmo_q, tmo_d;
  logic        wait_st, tmo_hit, retire;
  logic [CTRL_W-1:0] dec_word;

  // Branch resolution happens in the datapath, so the zero flag is not needed here.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  always_comb begin
    wait_st    = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    tmo_hit    = TMO_EN && wait_st && !mem_ready && (tmo_q == TMO_LAST);
    state_d    = state_q;
    illegal_d  = 1'b0;
    is_rtype_d = is_rtype_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        is_rtype_d = (opcode[5:4] == 2'b00);
        case (op_class(opcode))
          C_RTYPE: state_d = S_EXEC_R;
          C_ITYPE: state_d = S_EXEC_I;
          C_LW,
          C_SW:    state_d = S_MEM_ADDR;
          C_BNE:   state_d = S_BRANCH;
          C_JUMP:  state_d = S_JUMP;
          C_HALT:  state_d = S_HALT;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R,
      S_EXEC_I:    state_d = S_ALU_WB;
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
    if (tmo_hit) begin
      state_d   = S_FETCH;
      illegal_d = 1'b1;
    end
    tmo_d  = (TMO_EN && wait_st && !mem_ready && !tmo_hit) ? tmo_q + 32'd1 : 32'd0;
    retire = (state_d == S_FETCH) &&
             ((state_q == S_ALU_WB) || (state_q == S_MEM_WB) || (state_q == S_MEM_WRITE) ||
              (state_q == S_BRANCH) || (state_q == S_JUMP));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      is_rtype_q <= 1'b0;
      illegal_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_rtype_q <= is_rtype_d;
      illegal_q  <= illegal_d;
      tmo_q      <= tmo_d;
    end
  end

  seq_ctrl_decode u_decode (
    .state_i     (state_q),
    .is_rtype_i  (is_rtype_q),
    .mem_ready_i (mem_ready),
    .ctrl_word_o (dec_word)
  );

  assign ctrl_word  = reset ? '0 : dec_word;
  assign state_dbg  = state_q;
  assign halted     = (state_q == S_HALT);
  assign illegal_op = illegal_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_q, retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  assign cycle_count   = cycle_q;
  assign instr_retired = retired_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign cycle_count   = '0;
  assign instr_retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: per-instruction expected traces built from latency rules.
module tb_multicycle_sequencer;
  import seq_pkg::*;

  localparam int TMO   = 5;
  localparam int NRAND = 150;
  localparam int CL_R = 0, CL_I = 1, CL_LW = 2, CL_SW = 3, CL_BNE = 4, CL_J = 5, CL_HALT = 6, CL_ILL = 7;

  logic        clk = 1'b0;
  logic        reset, alu_zero, mem_ready;
  logic [5:0]  opcode;
  logic [15:0] ctrl_word;
  logic [3:0]  state_dbg;
  logic        halted, illegal_op;
  logic [31:0] cycle_count, instr_retired;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(TMO), .CTRL_WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .alu_zero      (alu_zero),
    .mem_ready     (mem_ready),
    .ctrl_word     (ctrl_word),
    .state_dbg     (state_dbg),
    .halted        (halted),
    .illegal_op    (illegal_op),
    .cycle_count   (cycle_count),
    .instr_retired (instr_retired)
  );

  typedef struct {
    logic [3:0]  st;
    logic [15:0] cw;
    logic        mr;
    logic        ill;
    logic        ret;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_cyc    = 0;
  int   m_ret    = 0;
  logic pend_ill = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Fields in datapath order: PCWriteCond PCWrite IorD MemRead MemWrite MemtoReg IRWrite PCSource ALUOp ALUSrcB ALUSrcA RegWrite RegDst
  function automatic logic [15:0] mk(input logic pcwc, input logic pcw, input logic iord, input logic mrd,
                                     input logic mwr, input logic m2r, input logic irw, input logic [1:0] pcs,
                                     input logic [1:0] aop, input logic [1:0] sb, input logic sa,
                                     input logic rw, input logic rd);
    return {pcwc, pcw, iord, mrd, mwr, m2r, irw, pcs, aop, sb, sa, rw, rd};
  endfunction

  function automatic logic [15:0] exp_cw(input logic [3:0] st, input logic rdy, input logic rt);
    logic [15:0] w;
    w = 16'h0;
    case (st)
      S_FETCH:     w = mk(0, rdy, 0, 1, 0, 0, rdy, 2'd0, 2'd0, 2'd1, 0, 0, 0);
      S_DECODE:    w = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd3, 0, 0, 0);
      S_EXEC_R:    w = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 1, 0, 0);
      S_EXEC_I:    w = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd3, 2'd2, 1, 0, 0);
      S_ALU_WB:    w = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 1, rt);
      S_MEM_ADDR:  w = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 1, 0, 0);
      S_MEM_READ:  w = mk(0, 0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
      S_MEM_WB:    w = mk(0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 0, 1, 0);
      S_MEM_WRITE: w = mk(0, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
      S_BRANCH:    w = mk(1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 1, 0, 0);
      S_JUMP:      w = mk(0, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 0, 0, 0);
      default:     w = 16'h0;
    endcase
    return w;
  endfunction

  function automatic logic is_illegal(input logic [5:0] op);
    return op[5] && op != 6'b100000 && op != 6'b100001 && op != 6'b110000 &&
           op != 6'b110001 && op != 6'b111111;
  endfunction

  function automatic logic [5:0] gen_op(input int cls);
    logic [5:0] op;
    case (cls)
      CL_R:    op = {2'b00, 4'($urandom)};
      CL_I:    op = {2'b01, 4'($urandom)};
      CL_LW:   op = 6'b100000;
      CL_SW:   op = 6'b100001;
      CL_BNE:  op = 6'b110000;
      CL_J:    op = 6'b110001;
      CL_HALT: op = 6'b111111;
      default: begin
        op = {1'b1, 5'($urandom)};
        if (!is_illegal(op)) op = 6'b101010;
      end
    endcase
    return op;
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input logic rt, input logic ret);
    ent_t e;
    e.st  = st;
    e.mr  = mr;
    e.cw  = exp_cw(st, mr, rt);
    e.ill = pend_ill;
    e.ret = ret;
    pend_ill = 1'b0;
    q.push_back(e);
  endtask

  // fw/mw: cycles mem_ready stays low in FETCH / the memory state; TMO or more means timeout.
  task automatic build(input int cls, input int fw, input int mw);
    logic rt;
    rt = (cls == CL_R);
    q.delete();
    for (int i = 0; i < fw && i < TMO; i++) push(S_FETCH, 1'b0, rt, 1'b0);
    if (fw >= TMO) begin
      pend_ill = 1'b1;
      return;
    end
    push(S_FETCH, 1'b1, rt, 1'b0);
    push(S_DECODE, 1'($urandom), rt, 1'b0);
    case (cls)
      CL_R, CL_I: begin
        push((cls == CL_R) ? S_EXEC_R : S_EXEC_I, 1'($urandom), rt, 1'b0);
        push(S_ALU_WB, 1'($urandom), rt, 1'b1);
      end
      CL_LW: begin
        push(S_MEM_ADDR, 1'($urandom), rt, 1'b0);
        for (int i = 0; i < mw && i < TMO; i++) push(S_MEM_READ, 1'b0, rt, 1'b0);
        if (mw >= TMO) begin
          pend_ill = 1'b1;
          return;
        end
        push(S_MEM_READ, 1'b1, rt, 1'b0);
        push(S_MEM_WB, 1'($urandom), rt, 1'b1);
      end
      CL_SW: begin
        push(S_MEM_ADDR, 1'($urandom), rt, 1'b0);
        for (int i = 0; i < mw && i < TMO; i++) push(S_MEM_WRITE, 1'b0, rt, 1'b0);
        if (mw >= TMO) begin
          q[q.size()-1].ret = 1'b1;
          pend_ill = 1'b1;
          return;
        end
        push(S_MEM_WRITE, 1'b1, rt, 1'b1);
      end
      CL_BNE:  push(S_BRANCH, 1'($urandom), rt, 1'b1);
      CL_J:    push(S_JUMP, 1'($urandom), rt, 1'b1);
      CL_HALT: for (int i = 0; i < 3; i++) push(S_HALT, 1'($urandom), rt, 1'b0);
      default: pend_ill = 1'b1;
    endcase
  endtask

  task automatic run_trace(input logic [5:0] op);
    foreach (q[i]) begin
      opcode    = op;
      mem_ready = q[i].mr;
      alu_zero  = 1'($urandom);
      #2;
      check("state_dbg", 32'(state_dbg), 32'(q[i].st));
      check("ctrl_word", 32'(ctrl_word), 32'(q[i].cw));
      check("illegal_op", 32'(illegal_op), 32'(q[i].ill));
      check("halted", 32'(halted), 32'(q[i].st == S_HALT));
`ifdef SEQ_PERF_CNT_EN
      check("cycle_count", cycle_count, 32'(m_cyc));
      check("instr_retired", instr_retired, 32'(m_ret));
`else
      check("cycle_count", cycle_count, 32'd0);
      check("instr_retired", instr_retired, 32'd0);
`endif
      m_cyc++;
      if (q[i].ret) m_ret++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic txn(input int idx, input int cls, input logic [5:0] op, input int fw, input int mw);
    build(cls, fw, mw);
    run_trace(op);
    $display("txn %0d op=%b class=%0d fetch_wait=%0d mem_wait=%0d cycles=%0d", idx, op, cls, fw, mw, q.size());
  endtask

  initial begin
    int cls, fw, mw;
    reset = 1'b1; opcode = 6'd0; mem_ready = 1'b1; alu_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl_word", 32'(ctrl_word), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(S_FETCH));
    reset = 1'b0;

    txn(0, CL_R,   6'b000010, 0, 0);
    txn(1, CL_LW,  6'b100000, 0, 3);
    txn(2, CL_SW,  6'b100001, 0, 0);
    txn(3, CL_BNE, 6'b110000, 0, 0);
    txn(4, CL_ILL, 6'b101010, 0, 0);
    txn(5, CL_R,   6'b000111, TMO, 0);
    txn(6, CL_I,   6'b010101, 1, 0);
    txn(7, CL_SW,  6'b100001, 2, TMO);
    txn(8, CL_LW,  6'b100000, 0, TMO);
    txn(9, CL_J,   6'b110001, 0, 0);

    for (int n = 0; n < NRAND; n++) begin
      cls = $urandom_range(0, 7);
      if (cls == CL_HALT) cls = CL_J;
      fw = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 4);
      txn(10 + n, cls, gen_op(cls), fw, mw);
    end

    txn(10 + NRAND, CL_HALT, 6'b111111, 0, 0);
    reset = 1'b1; mem_ready = 1'b1;
    #2;
    check("halt_reset_ctrl_word", 32'(ctrl_word), 32'd0);
    check("halt_reset_halted", 32'(halted), 32'd1);
    @(posedge clk);
    #1;
    check("reset2_ctrl_word", 32'(ctrl_word), 32'd0);
    check("reset2_state", 32'(state_dbg), 32'(S_FETCH));
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_cyc = 0; m_ret = 0; pend_ill = 1'b0;
    txn(11 + NRAND, CL_R, 6'b000001, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
